lpf_boxcar_mc: RTL
==================

# lpf_boxcar_mc

Multi-channel, time-multiplexed moving-average (boxcar) low-pass filter for sound-source post-processing. It is the parametrised successor of the single-channel OPLL LPF, generalised in channel count, widths, window length, decimation and gain. One shared accumulate/scale/saturate datapath processes channels serially. It sits between a sound core (OPLL/PSG/SCC outputs) and the cartridge mixer/limiter.

## Interface
Parameters:
- CHANNELS, 2, number of filtered channels (1..8)
- IN_WIDTH, 10, signed input sample width
- OUT_WIDTH, 10, signed output sample width
- PERIOD, 18, window length in samples (2..64)
- DIV, 4, CLK_EN pulses per sample tick (>=1)
- GAIN_M, 1, unsigned gain multiplier (1..15)
- GAIN_SHIFT, 4, arithmetic right shift after multiply

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - CLK in 1 system clock
  - RESET in 1 synchronous active-high reset
- CLK_EN in 1 sample-rate enable (21M enable domain)
- CLEAR in 1 synchronous history flush
- IN in CHANNELS*IN_WIDTH signed samples, ch0 in LSBs
- OUT out CHANNELS*OUT_WIDTH filtered samples, ch0 in LSBs
- OUT_STB out 1 one-cycle pulse when OUT updates
- BUSY out 1 high while channels are being processed
- OVERRUN out 1 sticky: a tick arrived while BUSY

## Operation
- Divider counts CLK_EN pulses 0..DIV-1 and wraps. Tick = CLK_EN while div==0.
- On a tick in IDLE, IN is latched as a whole vector, ch=0, and the FSM moves to RD.
- On a tick while not IDLE, the sample is dropped and OVERRUN is set. OVERRUN clears only on RESET.
- FSM per channel:
  - RD: issue history read at [index][ch].
  - ACC: if count==PERIOD, sum[ch] += in−old; else sum[ch] += in. Write in to [index][ch].
  - SCL: amp = (sum[ch]*GAIN_M) >>> GAIN_SHIFT, floor rounding.
  - SAT: clip amp to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1] into a shadow slice. If ch==CHANNELS−1, go to DONE; else ch+1 and go to RD.
  - DONE: OUT <= shadow (all channels at once), OUT_STB=1. index wraps PERIOD−1→0. count increments, saturating at PERIOD. Go to IDLE.
- Widths:
  - SUM_W = IN_WIDTH + clog2(PERIOD+1), two's complement; never overflows.
  - Product width = SUM_W + clog2(GAIN_M+1).
- Warm-up: while count<PERIOD, stale history is ignored (partial sums, no normalisation).
- CLEAR (or RESET) zeroes sums, count, index, div and shadow, and returns the FSM to IDLE, aborting any pass.
  - CLEAR keeps OUT and OVERRUN; RESET zeroes them too.
  - History RAM is not cleared; count==0 masks it.
- CLEAR coinciding with a tick: CLEAR wins, sample discarded, OVERRUN unaffected.

## Timing
- Reset values: OUT=0, OUT_STB=0, BUSY=0, OVERRUN=0.
- Tick cycle T: latch. RD at T+1. OUT_STB at T+4*CHANNELS+1, OUT valid the same cycle.
- BUSY is high from T+1 through the DONE cycle inclusive.
- Overrun-free operation requires tick spacing ≥ 4*CHANNELS+2 clocks. With CLK_EN=1 continuously, that means DIV ≥ 4*CHANNELS+2.
- History RAM has a 1-cycle synchronous read. Read and write to the same address never coincide in one cycle.

## Structure
- Package lpf_pkg:
  - state enum {IDLE, RD, ACC, SCL, SAT, DONE}
  - functions sum_width(IN_WIDTH, PERIOD) and sat_clip(value, OUT_WIDTH)
- Sub-module lpf_history_ram: CHANNELS*PERIOD × IN_WIDTH, one write port and one sync read port, address {index, ch}, inferable as BRAM.
- Per-channel sums are a register array indexed by ch.

## Test plan
- Reset: assert RESET for 2 clocks mid-pass → OUT=0, OUT_STB=0, BUSY=0, OVERRUN=0 next clock.
- Warm-up (CHANNELS=2, PERIOD=4, GAIN_M=1, GAIN_SHIFT=2, DIV=16, CLK_EN=1), ch0=+100, ch1=−100:
  - ch0 → 25, 50, 75, 100, 100.
  - ch1 → −25, −50, −75, −100.
  - OUT_STB exactly 9 clocks after each tick.
- Slide (same config): after 4 ticks of 100, ch0 steps to 0 → 75, 50, 25, 0, 0.
- Saturation (OUT_WIDTH=8, GAIN_M=4, GAIN_SHIFT=2, PERIOD=4):
  - constant +511 → +127 from the first output.
  - constant −512 → −128.
- Overrun: DIV=4, CHANNELS=2, CLK_EN=1 → tick at T+4 while BUSY sets OVERRUN; one OUT_STB per accepted tick; dropped samples leave sums unchanged.
- CLEAR at T+3 of a pass → no OUT_STB for that pass, BUSY low next clock. Next tick with ch0=100 yields 25 (warm-up restarted).

Source files
------------

// File: rtl/lpf_pkg.sv
// Shared types and helpers for the multi-channel boxcar low-pass filter.
// Holds the FSM state encoding, accumulator sizing and output clipping.
package lpf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        ACC,
        SCL,
        SAT,
        DONE
    } state_e;

    localparam int CALC_W = 64;

    // Accumulator must hold PERIOD full-scale samples without wrapping.
    function automatic int sum_width(input int in_width, input int period);
        return in_width + $clog2(period + 1);
    endfunction

    function automatic logic signed [CALC_W-1:0] sat_clip(
        input logic signed [CALC_W-1:0] value,
        input int                       out_width
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = (CALC_W'(1) << (out_width - 1)) - CALC_W'(1);
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/lpf_history_ram.sv
// Sample history store: one write port and one registered read port.
// Contents are never reset; the owner masks stale entries itself.
module lpf_history_ram #(
    parameter int DEPTH  = 36,
    parameter int WIDTH  = 10,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lpf_boxcar_mc.sv
// Time-multiplexed multi-channel moving-average filter: one shared
// accumulate / scale / saturate datapath walks the channels serially.
module lpf_boxcar_mc
    import lpf_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int IN_WIDTH   = 10,
    parameter int OUT_WIDTH  = 10,
    parameter int PERIOD     = 18,
    parameter int DIV        = 4,
    parameter int GAIN_M     = 1,
    parameter int GAIN_SHIFT = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          CLK_EN,
    input  logic                          CLEAR,
    input  logic [CHANNELS*IN_WIDTH-1:0]  IN,
    output logic [CHANNELS*OUT_WIDTH-1:0] OUT,
    output logic                          OUT_STB,
    output logic                          BUSY,
    output logic                          OVERRUN,
    output state_e                        state_dbg
);

    localparam int SUM_W  = sum_width(IN_WIDTH, PERIOD);
    localparam int PROD_W = SUM_W + $clog2(GAIN_M + 1);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IDX_W  = $clog2(PERIOD);
    localparam int CNT_W  = $clog2(PERIOD + 1);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH  = CHANNELS * PERIOD;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic signed [PROD_W-1:0] GAIN_S = PROD_W'(GAIN_M);

    state_e                        state_q, state_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [DIV_W-1:0]              div_q, div_d;
    logic [IDX_W-1:0]              index_q, index_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic signed [IN_WIDTH-1:0]    in_lat_q [CHANNELS];
    logic signed [IN_WIDTH-1:0]    in_lat_d [CHANNELS];
    logic signed [SUM_W-1:0]       sum_q [CHANNELS];
    logic signed [SUM_W-1:0]       sum_d [CHANNELS];
    logic signed [OUT_WIDTH-1:0]   shadow_q [CHANNELS];
    logic signed [OUT_WIDTH-1:0]   shadow_d [CHANNELS];
    logic signed [PROD_W-1:0]      amp_q, amp_d;
    logic [CHANNELS*OUT_WIDTH-1:0] out_q, out_d;
    logic                          out_stb_q, out_stb_d;
    logic                          overrun_q, overrun_d;

    logic                          tick;
    logic                          full;
    logic                          ram_we;
    logic                          ram_re;
    logic [ADDR_W-1:0]             ram_addr;
    logic [IN_WIDTH-1:0]           ram_rdata;
    logic signed [IN_WIDTH-1:0]    in_cur;
    logic signed [SUM_W-1:0]       in_ext;
    logic signed [SUM_W-1:0]       old_ext;
    logic signed [SUM_W-1:0]       sum_cur;
    logic signed [PROD_W-1:0]      sum_wide;
    logic signed [PROD_W-1:0]      prod;
    logic signed [CALC_W-1:0]      amp_wide;

    // A tick is only accepted in IDLE; OUT_STB flags a fresh OUT vector with
    // no back-pressure, so a tick arriving mid-pass is dropped and recorded.
    assign tick     = CLK_EN && (div_q == '0);
    assign full     = (count_q == CNT_W'(PERIOD));
    assign ram_addr = ADDR_W'(ADDR_W'(index_q) * ADDR_W'(CHANNELS) + ADDR_W'(ch_q));
    assign in_cur   = in_lat_q[ch_q];
    assign in_ext   = {{(SUM_W-IN_WIDTH){in_cur[IN_WIDTH-1]}}, in_cur};
    assign old_ext  = full ? {{(SUM_W-IN_WIDTH){ram_rdata[IN_WIDTH-1]}}, ram_rdata} : '0;
    assign sum_cur  = sum_q[ch_q];
    assign sum_wide = {{(PROD_W-SUM_W){sum_cur[SUM_W-1]}}, sum_cur};
    assign prod     = sum_wide * GAIN_S;
    assign amp_wide = {{(CALC_W-PROD_W){amp_q[PROD_W-1]}}, amp_q};

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        div_d     = div_q;
        index_d   = index_q;
        count_d   = count_q;
        in_lat_d  = in_lat_q;
        sum_d     = sum_q;
        shadow_d  = shadow_q;
        amp_d     = amp_q;
        out_d     = out_q;
        out_stb_d = 1'b0;
        overrun_d = overrun_q;
        ram_we    = 1'b0;
        ram_re    = 1'b0;

        if (CLK_EN) begin
            div_d = (div_q == DIV_W'(DIV - 1)) ? '0 : div_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        in_lat_d[c] = IN[c*IN_WIDTH +: IN_WIDTH];
                    end
                    ch_d    = '0;
                    state_d = RD;
                end
            end
            RD: begin
                ram_re  = 1'b1;
                state_d = ACC;
            end
            ACC: begin
                ram_we       = 1'b1;
                sum_d[ch_q]  = sum_cur + in_ext - old_ext;
                state_d      = SCL;
            end
            SCL: begin
                amp_d   = prod >>> GAIN_SHIFT;
                state_d = SAT;
            end
            SAT: begin
                shadow_d[ch_q] = OUT_WIDTH'(sat_clip(amp_wide, OUT_WIDTH));
                if (ch_q == CH_W'(CHANNELS - 1)) begin
                    // OUT is loaded here so it is already valid in the DONE cycle.
                    for (int c = 0; c < CHANNELS; c++) begin
                        out_d[c*OUT_WIDTH +: OUT_WIDTH] = shadow_d[c];
                    end
                    out_stb_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = RD;
                end
            end
            DONE: begin
                index_d = (index_q == IDX_W'(PERIOD - 1)) ? '0 : index_q + 1'b1;
                count_d = full ? count_q : count_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        if (CLEAR) begin
            state_d   = IDLE;
            ch_d      = '0;
            div_d     = '0;
            index_d   = '0;
            count_d   = '0;
            out_d     = out_q;
            out_stb_d = 1'b0;
            overrun_d = overrun_q;
            ram_we    = 1'b0;
            ram_re    = 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                sum_d[c]    = '0;
                shadow_d[c] = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            div_q     <= '0;
            index_q   <= '0;
            count_q   <= '0;
            amp_q     <= '0;
            out_q     <= '0;
            out_stb_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                in_lat_q[c] <= '0;
                sum_q[c]    <= '0;
                shadow_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            div_q     <= div_d;
            index_q   <= index_d;
            count_q   <= count_d;
            amp_q     <= amp_d;
            out_q     <= out_d;
            out_stb_q <= out_stb_d;
            overrun_q <= overrun_d;
            for (int c = 0; c < CHANNELS; c++) begin
                in_lat_q[c] <= in_lat_d[c];
                sum_q[c]    <= sum_d[c];
                shadow_q[c] <= shadow_d[c];
            end
        end
    end

    lpf_history_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (IN_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_hist (
        .clk   (CLK),
        .we    (ram_we),
        .waddr (ram_addr),
        .wdata (in_cur),
        .re    (ram_re),
        .raddr (ram_addr),
        .rdata (ram_rdata)
    );

    assign OUT       = out_q;
    assign OUT_STB   = out_stb_q;
    assign BUSY      = (state_q != IDLE);
    assign OVERRUN   = overrun_q;
    assign state_dbg = state_q;

endmodule
